// File: rtl/mux_16b_4_input.sv
// Four-input WIDTH-bit selector with a clocked shadow stage that captures the
// selected word and select code and flags select-code changes.
module mux_16b_4_input #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       Op,
    input  logic             En,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Output_Reg,
    output logic [1:0]       Op_Reg,
    output logic             Sel_Changed
);

    // The default arm only fires for X/Z select codes, so simulation shows
    // all-X there while synthesis sees a fully specified mux.
    always_comb begin
        Output = 'x;
        case (Op)
            2'b00:   Output = A;
            2'b01:   Output = B;
            2'b10:   Output = C;
            2'b11:   Output = D;
            default: Output = 'x;
        endcase
    end

    // Shadow stage: reset wins over En; Sel_Changed is a single-cycle pulse
    // because any non-loading edge drops it.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            Output_Reg  <= '0;
            Op_Reg      <= 2'b00;
            Sel_Changed <= 1'b0;
        end else if (En) begin
            Output_Reg  <= Output;
            Op_Reg      <= Op;
            Sel_Changed <= (Op != Op_Reg);
        end else begin
            Sel_Changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_16b_4_input.sv
// Self-checking bench for mux_16b_4_input: directed scenarios followed by
// randomized cycles compared against a behavioural word-table model.
module tb_mux_16b_4_input;

    localparam int WIDTH = 16;

    logic             CLK;
    logic             clk_on;
    logic             Reset;
    logic [WIDTH-1:0] A, B, C, D;
    logic [1:0]       Op;
    logic             En;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Output_Reg;
    logic [1:0]       Op_Reg;
    logic             Sel_Changed;

    int n_checks = 0;
    int n_pass   = 0;

    mux_16b_4_input #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .Op         (Op),
        .En         (En),
        .Output     (Output),
        .Output_Reg (Output_Reg),
        .Op_Reg     (Op_Reg),
        .Sel_Changed(Sel_Changed)
    );

    initial CLK = 1'b0;
    always #5 CLK = clk_on ? ~CLK : CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: the selected word is a table lookup; the shadow stage
    // is three plain variables advanced once per edge.
    function automatic logic [WIDTH-1:0] pick(input logic [1:0] sel);
        logic [WIDTH-1:0] words [4];
        words[0] = A; words[1] = B; words[2] = C; words[3] = D;
        return words[sel];
    endfunction

    logic [WIDTH-1:0] m_out;
    logic [1:0]       m_op;
    logic             m_sel;

    initial begin
        logic [WIDTH-1:0] n_out;
        logic [1:0]       n_op;
        logic             n_sel;

        clk_on = 1'b0;
        Reset  = 1'b0;
        En     = 1'b0;
        A = 16'd570; B = 16'd1344; C = 16'd3465; D = 16'd8949;
        Op = 2'b00;

        // combinational path with no clock running
        #100 check("out_op00", Output, 32'd570);
        Op = 2'b01; #20 check("out_op01", Output, 32'd1344);
        Op = 2'b10; #20 check("out_op10", Output, 32'd3465);
        Op = 2'b11; #20 check("out_op11", Output, 32'd8949);
        Op = 2'b10;
        A = 16'hFFFF; B = 16'hFFFF; D = 16'hFFFF;
        #20 check("out_unsel", Output, 32'd3465);
        C = 16'h0000;
        #20 check("out_sel_chg", Output, 32'h0000);

        A = 16'd570; B = 16'd1344; C = 16'd3465; D = 16'd8949;
        clk_on = 1'b1;

        // reset, then first load with a new select
        Reset = 1'b0; En = 1'b1;
        tick(); tick();
        check("rst_out_reg", Output_Reg, 32'd0);
        check("rst_op_reg", Op_Reg, 32'd0);
        check("rst_sel", Sel_Changed, 32'd0);
        Reset = 1'b1; En = 1'b1; Op = 2'b11; D = 16'd8949;
        tick();
        check("load_out_reg", Output_Reg, 32'd8949);
        check("load_op_reg", Op_Reg, 32'd3);
        check("load_sel", Sel_Changed, 32'd1);
        tick();
        check("sel_pulse_end", Sel_Changed, 32'd0);

        // hold with En low while the select moves
        En = 1'b0; Op = 2'b01;
        #1 check("hold_out_comb", Output, 32'd1344);
        tick();
        check("hold_out_reg", Output_Reg, 32'd8949);
        check("hold_op_reg", Op_Reg, 32'd3);
        check("hold_sel", Sel_Changed, 32'd0);
        En = 1'b1;
        tick();
        check("reload_out_reg", Output_Reg, 32'd1344);
        check("reload_sel", Sel_Changed, 32'd1);

        // reset mid-operation beats En
        Reset = 1'b0;
        tick();
        check("midrst_out_reg", Output_Reg, 32'd0);
        check("midrst_op_reg", Op_Reg, 32'd0);
        check("midrst_sel", Sel_Changed, 32'd0);
        check("midrst_out_comb", Output, 32'd1344);

        // first load after reset with Op = 00 does not flag
        Reset = 1'b1; Op = 2'b00;
        tick();
        check("first00_out_reg", Output_Reg, 32'd570);
        check("first00_sel", Sel_Changed, 32'd0);

        m_out = Output_Reg; m_op = 2'b00; m_sel = 1'b0;

        for (int i = 0; i < 400; i++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom);
            C = WIDTH'($urandom); D = WIDTH'($urandom);
            Op    = 2'($urandom_range(0, 3));
            En    = ($urandom_range(0, 3) != 0);
            Reset = ($urandom_range(0, 15) != 0);
            #1 check("rnd_out", Output, 32'(pick(Op)));
            if (!Reset) begin
                n_out = '0; n_op = 2'b00; n_sel = 1'b0;
            end else if (En) begin
                n_out = pick(Op); n_op = Op; n_sel = (Op != m_op);
            end else begin
                n_out = m_out; n_op = m_op; n_sel = 1'b0;
            end
            tick();
            m_out = n_out; m_op = n_op; m_sel = n_sel;
            check("rnd_out_reg", Output_Reg, 32'(m_out));
            check("rnd_op_reg", Op_Reg, 32'(m_op));
            check("rnd_sel", Sel_Changed, 32'(m_sel));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_16b_4_input.md
# mux_16b_4_input

Four-input, 16-bit-wide selector for the accumulator processor datapath (ALU operand and writeback source selection). A 2-bit `Op` code selects one of four data words onto a purely combinational `Output`. A clocked shadow stage registers the selected word and select code, and flags select changes for pipeline control and debug.

## Interface

Parameters
- `WIDTH`, 16: data width of A, B, C, D, Output, Output_Reg.

Ports
- One clock; reset is synchronous and active-low.
- `CLK`  input  1  rising-edge clock; only the shadow registers use it.
- `Reset`  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- `A`  input  WIDTH  data input, selected when Op = 2'b00.
- `B`  input  WIDTH  data input, selected when Op = 2'b01.
- `C`  input  WIDTH  data input, selected when Op = 2'b10.
- `D`  input  WIDTH  data input, selected when Op = 2'b11.
- `Op`  input  2  select code.
- `En`  input  1  shadow register load enable, active-high.
- `Output`  output  WIDTH  combinational selected word.
- `Output_Reg`  output  WIDTH  registered copy of Output.
- `Op_Reg`  output  2  registered copy of Op.
- `Sel_Changed`  output  1  registered pulse: Op differed from Op_Reg at the last loading edge.

## Operation

- Output = A / B / C / D for Op = 00 / 01 / 10 / 11. The path is fully combinational and does not depend on CLK, Reset or En.
- Output follows any change of Op or of the selected input with no clock required.
- Changes on unselected inputs have no effect on Output.
- Op containing X or Z drives Output to all-X in simulation. Synthesis uses a full case with no latch inferred.
- Shadow stage, on each rising edge of CLK:
  - Reset = 0: Output_Reg <= 0, Op_Reg <= 2'b00, Sel_Changed <= 0. Reset has priority over En.
  - Reset = 1 and En = 1: Output_Reg <= Output, Op_Reg <= Op, Sel_Changed <= (Op != Op_Reg).
  - Reset = 1 and En = 0: Output_Reg and Op_Reg hold their values, Sel_Changed <= 0.
- Sel_Changed is high for exactly one cycle per detected change.
- The first load after reset compares against the reset value 00, so loading with Op = 00 does not flag a change.
- No arithmetic is performed. The data path is a bit-for-bit copy at full WIDTH, with no extension or truncation.

## Timing

- Output: zero-cycle latency, combinational from A/B/C/D/Op. It must settle well within 20 ns of an input change.
- Output_Reg and Op_Reg: one-cycle latency from a loading edge.
- Sel_Changed: asserted in the cycle after the edge that loaded the new Op.
- Reset asserted mid-operation:
  - Registered outputs clear at the next edge.
  - Output keeps tracking its inputs throughout reset.
- Before the first clock edge, registered outputs are undefined. Benches must apply reset first.
- Op and the selected input changing in the same cycle: the registered value is the new word on the new select, with no glitch capture requirement beyond setup/hold.

## Test plan

- A=570, B=1344, C=3465, D=8949, Op=00, no clock toggling -> after 100 ns, Output = 570.
- Same data; Op=01, then 10, then 11, each checked 20 ns after the change -> Output = 1344, 3465, 8949 respectively.
- Op=10 held; change A, B and D to 16'hFFFF, then change C to 16'h0000 -> Output stays 3465 until C changes, then reads 16'h0000.
- Reset=0 for 2 cycles, then Reset=1, En=1, Op=11, D=8949 -> after one edge, Output_Reg = 8949, Op_Reg = 11, Sel_Changed = 1. On the following edge with Op unchanged, Sel_Changed = 0.
- En=0 while Op changes 11 -> 01 -> Output_Reg holds 8949, Op_Reg holds 11, Sel_Changed = 0, while Output = 1344 immediately.
- With registers loaded, assert Reset=0 at an edge with En=1 -> Output_Reg = 0, Op_Reg = 00, Sel_Changed = 0. Output still equals the currently selected input.
